// File: rtl/rv_dmem_arb_if.sv
// Shared data-memory port bundle: CPU requester, external requester and the memory side.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_A_BIT
`define DMEM_A_BIT 12
`endif

interface rv_dmem_arb_if;
    logic                   i_cpu_req;
    logic [`DMEM_A_BIT-1:0] i_cpu_a;
    logic [`XLEN-1:0]       i_cpu_wd;
    logic                   i_cpu_we;
    logic [2:0]             i_cpu_bytectrl;
    logic                   o_cpu_gnt;
    logic                   o_cpu_stall;
    logic [`XLEN-1:0]       o_cpu_rd;

    logic                   i_ext_req;
    logic                   i_ext_lock;
    logic [`DMEM_A_BIT-1:0] i_ext_a;
    logic [`XLEN-1:0]       i_ext_wd;
    logic                   i_ext_we;
    logic [2:0]             i_ext_bytectrl;
    logic                   o_ext_gnt;
    logic [`XLEN-1:0]       o_ext_rd;

    logic [`DMEM_A_BIT-1:0] o_dmem_a;
    logic [`XLEN-1:0]       o_dmem_wd;
    logic                   o_dmem_we;
    logic [2:0]             o_dmem_bytectrl;
    logic [`XLEN-1:0]       i_dmem_rd;

    modport slave (
        input  i_cpu_req, i_cpu_a, i_cpu_wd, i_cpu_we, i_cpu_bytectrl,
        output o_cpu_gnt, o_cpu_stall, o_cpu_rd,
        input  i_ext_req, i_ext_lock, i_ext_a, i_ext_wd, i_ext_we, i_ext_bytectrl,
        output o_ext_gnt, o_ext_rd,
        output o_dmem_a, o_dmem_wd, o_dmem_we, o_dmem_bytectrl,
        input  i_dmem_rd
    );

    modport master (
        output i_cpu_req, i_cpu_a, i_cpu_wd, i_cpu_we, i_cpu_bytectrl,
        input  o_cpu_gnt, o_cpu_stall, o_cpu_rd,
        output i_ext_req, i_ext_lock, i_ext_a, i_ext_wd, i_ext_we, i_ext_bytectrl,
        input  o_ext_gnt, o_ext_rd,
        input  o_dmem_a, o_dmem_wd, o_dmem_we, o_dmem_bytectrl,
        output i_dmem_rd
    );
endinterface

// File: rtl/rv_dmem_arb.sv
// Data-memory port arbiter: CPU priority, starvation-bounded external access,
// and length-bounded locked external bursts. Grants are same-cycle (combinational).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_A_BIT
`define DMEM_A_BIT 12
`endif

module rv_dmem_arb #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned BURST_MAX  = 8
) (
    input logic           i_dmem_arb_clk,
    input logic           i_dmem_arb_rstn,
    rv_dmem_arb_if.slave  bus
);

    typedef enum logic {S_CPU, S_EXT} state_t;

    state_t     state, state_nxt;
    logic [3:0] starve_cnt, starve_nxt;
    logic [3:0] burst_cnt, burst_nxt;
    logic [4:0] burst_inc;
    logic       ext_win;
    logic       cpu_gnt, ext_gnt;

    assign burst_inc = {1'b0, burst_cnt} + 5'd1;

    always_ff @(posedge i_dmem_arb_clk) begin
        if (!i_dmem_arb_rstn) begin
            state      <= S_CPU;
            starve_cnt <= 4'd0;
            burst_cnt  <= 4'd0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            burst_cnt  <= burst_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        ext_win   = 1'b0;
        cpu_gnt   = 1'b0;
        ext_gnt   = 1'b0;
        case (state)
            S_CPU: begin
                ext_win = bus.i_ext_req &
                          (~bus.i_cpu_req | (starve_cnt == 4'(STARVE_MAX)));
                ext_gnt = ext_win;
                cpu_gnt = bus.i_cpu_req & ~ext_win;
                if (ext_win && bus.i_ext_lock && (BURST_MAX > 1)) begin
                    state_nxt = S_EXT;
                    burst_nxt = 4'd1;
                end
            end
            S_EXT: begin
                // Inside a locked burst the external master owns the port
                // until it stops requesting or the burst length runs out.
                ext_gnt = bus.i_ext_req;
                cpu_gnt = bus.i_cpu_req & ~bus.i_ext_req;
                if (bus.i_ext_req) begin
                    burst_nxt = burst_inc[3:0];
                    if (!(bus.i_ext_lock && (burst_inc < 5'(BURST_MAX))))
                        state_nxt = S_CPU;
                end else begin
                    state_nxt = S_CPU;
                end
            end
            default: state_nxt = S_CPU;
        endcase
        if (!i_dmem_arb_rstn) begin
            cpu_gnt = 1'b0;
            ext_gnt = 1'b0;
        end
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (ext_gnt || !bus.i_ext_req)
            starve_nxt = 4'd0;
        else if (starve_cnt < 4'(STARVE_MAX))
            starve_nxt = starve_cnt + 4'd1;
    end

    assign bus.o_cpu_gnt       = cpu_gnt;
    assign bus.o_ext_gnt       = ext_gnt;
    assign bus.o_cpu_stall     = bus.i_cpu_req & ~cpu_gnt;

    assign bus.o_dmem_a        = ext_gnt ? bus.i_ext_a        : bus.i_cpu_a;
    assign bus.o_dmem_wd       = ext_gnt ? bus.i_ext_wd       : bus.i_cpu_wd;
    assign bus.o_dmem_bytectrl = ext_gnt ? bus.i_ext_bytectrl : bus.i_cpu_bytectrl;
    assign bus.o_dmem_we       = (cpu_gnt & bus.i_cpu_we) | (ext_gnt & bus.i_ext_we);

    assign bus.o_cpu_rd        = bus.i_dmem_rd;
    assign bus.o_ext_rd        = bus.i_dmem_rd;

endmodule

// File: tb/tb_rv_dmem_arb.sv
// Bench for rv_dmem_arb: vector table, corner sequences and random traffic vs. a grant model.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_A_BIT
`define DMEM_A_BIT 12
`endif

module tb_rv_dmem_arb;
    localparam int SM = 4;
    localparam int BM = 8;

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    rv_dmem_arb_if bus ();

    rv_dmem_arb #(.STARVE_MAX(SM), .BURST_MAX(BM)) dut (
        .i_dmem_arb_clk  (clk),
        .i_dmem_arb_rstn (rstn),
        .bus             (bus.slave)
    );

    always #5 clk = ~clk;

    // Word-wide memory behind the port; byte control is passed through only.
    logic [31:0] mem [0:63];
    assign bus.i_dmem_rd = mem[bus.o_dmem_a[7:2]];
    always @(posedge clk) if (bus.o_dmem_we) mem[bus.o_dmem_a[7:2]] <= bus.o_dmem_wd;

    // Model: how long ext has been waiting, and how many cycles the current burst has used.
    int m_waited = 0;
    int m_burst_len = 0;
    bit m_in_burst = 0;
    bit e_cg, e_eg;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [11:0] ea;
        if (!rstn) begin
            e_eg = 0; e_cg = 0;
        end else if (m_in_burst) begin
            e_eg = bus.i_ext_req;
            e_cg = bus.i_cpu_req & ~bus.i_ext_req;
        end else begin
            e_eg = bus.i_ext_req & (!bus.i_cpu_req || m_waited >= SM);
            e_cg = bus.i_cpu_req & ~e_eg;
        end
        ea = e_eg ? bus.i_ext_a : bus.i_cpu_a;
        chk("cpu_gnt", 32'(bus.o_cpu_gnt), 32'(e_cg));
        chk("ext_gnt", 32'(bus.o_ext_gnt), 32'(e_eg));
        chk("cpu_stall", 32'(bus.o_cpu_stall), 32'(bus.i_cpu_req & ~e_cg));
        chk("dmem_a", 32'(bus.o_dmem_a), 32'(ea));
        chk("dmem_wd", bus.o_dmem_wd, e_eg ? bus.i_ext_wd : bus.i_cpu_wd);
        chk("dmem_bc", 32'(bus.o_dmem_bytectrl), 32'(e_eg ? bus.i_ext_bytectrl : bus.i_cpu_bytectrl));
        chk("dmem_we", 32'(bus.o_dmem_we), 32'((e_cg & bus.i_cpu_we) | (e_eg & bus.i_ext_we)));
        chk("cpu_rd", bus.o_cpu_rd, mem[ea[7:2]]);
        chk("ext_rd", bus.o_ext_rd, mem[ea[7:2]]);
    endtask

    task automatic advance();
        if (!rstn) begin
            m_waited = 0; m_in_burst = 0; m_burst_len = 0;
        end else begin
            if (e_eg || !bus.i_ext_req) m_waited = 0;
            else if (m_waited < SM) m_waited++;
            if (e_eg) begin
                m_burst_len = m_in_burst ? m_burst_len + 1 : 1;
                m_in_burst  = bus.i_ext_lock && (m_burst_len < BM);
            end else begin
                m_in_burst = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input bit c, input bit e, input bit l,
                         input bit cwe, input bit ewe);
        rstn = r;
        bus.i_cpu_req = c; bus.i_ext_req = e; bus.i_ext_lock = l;
        bus.i_cpu_we = cwe; bus.i_ext_we = ewe;
        bus.i_cpu_a  = 12'($urandom); bus.i_ext_a = 12'($urandom);
        bus.i_cpu_wd = $urandom; bus.i_ext_wd = $urandom;
        bus.i_cpu_bytectrl = 3'($urandom); bus.i_ext_bytectrl = 3'($urandom);
    endtask

    typedef struct {
        bit rstn, cpu_req, ext_req, lock, cpu_we, ext_we;
        bit cg, eg, st, we;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit c, bit e, bit l, bit cwe, bit ewe,
                                bit cg, bit eg, bit st, bit we);
        vec_t v;
        v.rstn = r; v.cpu_req = c; v.ext_req = e; v.lock = l; v.cpu_we = cwe; v.ext_we = ewe;
        v.cg = cg; v.eg = eg; v.st = st; v.we = we;
        return v;
    endfunction

    int n_stall, n_cg;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;

        // Starvation: ext denied 4 cycles, forced on the 5th, CPU back on the 6th.
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1,1,1,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,1,1,0,0,0, 0,1,1,0));
        tbl.push_back(mk(1,1,1,0,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,1, 0,0,0,0));
        // Locked ext with idle CPU: granted every cycle across the burst boundary.
        for (int i = 0; i < 12; i++) tbl.push_back(mk(1,0,1,1,0,1, 0,1,0,1));
        // Reset mid-burst blocks the write; after release CPU is served at once.
        tbl.push_back(mk(0,1,1,1,0,1, 0,0,1,0));
        tbl.push_back(mk(1,1,0,0,1,0, 1,0,0,1));

        drive(0,1,0,0,1,0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            #1; check_model();
            chk("rst_stall", 32'(bus.o_cpu_stall), 32'd1);
            advance();
        end

        foreach (tbl[i]) begin
            drive(tbl[i].rstn, tbl[i].cpu_req, tbl[i].ext_req, tbl[i].lock,
                  tbl[i].cpu_we, tbl[i].ext_we);
            #1;
            chk($sformatf("tbl%0d_cg", i), 32'(bus.o_cpu_gnt), 32'(tbl[i].cg));
            chk($sformatf("tbl%0d_eg", i), 32'(bus.o_ext_gnt), 32'(tbl[i].eg));
            chk($sformatf("tbl%0d_st", i), 32'(bus.o_cpu_stall), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_we", i), 32'(bus.o_dmem_we), 32'(tbl[i].we));
            check_model();
            advance();
        end

        // Locked burst with CPU busy: 4 denied, 8 stalled, 4 CPU, then ext again.
        n_stall = 0; n_cg = 0;
        for (int i = 0; i < 17; i++) begin
            drive(1,1,1,1,0,0);
            #1; check_model();
            if (i < 4) chk("b3_denied", 32'(bus.o_ext_gnt), 32'd0);
            else if (i < 12) n_stall += int'(bus.o_cpu_stall);
            else if (i < 16) n_cg += int'(bus.o_cpu_gnt);
            else chk("b3_regrant", 32'(bus.o_ext_gnt), 32'd1);
            advance();
        end
        chk("b3_stall_cycles", 32'(n_stall), 32'd8);
        chk("b3_cpu_cycles", 32'(n_cg), 32'd4);

        // External store, then CPU load of the same word.
        drive(1,0,1,0,0,1);
        bus.i_ext_a = 12'h010; bus.i_ext_wd = 32'hDEADBEEF;
        #1; check_model();
        chk("sw_gnt", 32'(bus.o_ext_gnt), 32'd1);
        advance();
        drive(1,1,0,0,0,0);
        bus.i_cpu_a = 12'h010; bus.i_cpu_bytectrl = 3'b010;
        #1; check_model();
        chk("lw_rd", bus.o_cpu_rd, 32'hDEADBEEF);
        chk("lw_bc", 32'(bus.o_dmem_bytectrl), 32'd2);
        advance();
        drive(1,0,0,1,1,1);
        #1; check_model();
        chk("idle_we", 32'(bus.o_dmem_we), 32'd0);
        advance();

        // ext_req drops mid-burst: CPU served, then ext must starve again.
        drive(1,0,1,1,0,0);
        #1; check_model(); advance();
        drive(1,1,0,1,0,0);
        #1; check_model();
        chk("drop_cg", 32'(bus.o_cpu_gnt), 32'd1);
        chk("drop_eg", 32'(bus.o_ext_gnt), 32'd0);
        advance();
        for (int i = 0; i < 5; i++) begin
            drive(1,1,1,1,0,0);
            #1; check_model();
            chk("drop_starve", 32'(bus.o_ext_gnt), (i == 4) ? 32'd1 : 32'd0);
            advance();
        end

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 39) != 0), 1'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom));
            #1; check_model();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rv_dmem_arb.md
Name: rv_dmem_arb

Overview:
- Two-requester arbiter sharing the single data-memory port between the pipeline MEM stage (CPU) and an external master (debug/loader).
- The data memory reads combinationally and writes on the clock edge, so a grant is issued in the same cycle as the request.
- The block muxes address, write data, write enable and byte control to the memory, and returns read data plus a CPU stall.
- Policy is CPU priority, with a starvation bound and bounded locked bursts for the external master.

Parameters:
- STARVE_MAX, 4: maximum consecutive denied cycles for a pending external request before it is force-granted (legal range 1..15).
- BURST_MAX, 8: maximum consecutive granted cycles in one locked external burst (legal range 1..15).

Ports:
- i_dmem_arb_clk  input  1  clock.
- i_dmem_arb_rstn  input  1  reset; synchronous, active-low.
- i_cpu_req  input  1  CPU memory access request.
- i_cpu_a  input  `DMEM_A_BIT  CPU byte address.
- i_cpu_wd  input  `XLEN  CPU write data.
- i_cpu_we  input  1  CPU write enable.
- i_cpu_bytectrl  input  3  CPU byte control (word/half/halfu/byte/byteu encoding).
- o_cpu_gnt  output  1  CPU granted this cycle.
- o_cpu_stall  output  1  equals i_cpu_req & ~o_cpu_gnt.
- o_cpu_rd  output  `XLEN  read data; valid when o_cpu_gnt=1.
- i_ext_req  input  1  external request.
- i_ext_lock  input  1  request to keep the grant across consecutive cycles (burst).
- i_ext_a  input  `DMEM_A_BIT  external byte address.
- i_ext_wd  input  `XLEN  external write data.
- i_ext_we  input  1  external write enable.
- i_ext_bytectrl  input  3  external byte control.
- o_ext_gnt  output  1  external master granted this cycle.
- o_ext_rd  output  `XLEN  read data; valid when o_ext_gnt=1.
- o_dmem_a  output  `DMEM_A_BIT  address to memory.
- o_dmem_wd  output  `XLEN  write data to memory.
- o_dmem_we  output  1  write enable to memory.
- o_dmem_bytectrl  output  3  byte control to memory.
- i_dmem_rd  input  `XLEN  read data from memory.

Behaviour:
Reset:
- Synchronous: on a rising edge with rstn=0, state<=S_CPU, starve_cnt<=0, burst_cnt<=0.
- While rstn=0 both grants are forced to 0 and o_dmem_we=0 combinationally.
- Result: o_cpu_stall=i_cpu_req, and no write can occur during reset, including mid-burst.

Grant rules:
- Grants are combinational from inputs and registered state; o_cpu_gnt and o_ext_gnt are never both 1.
- Memory mux: select the external fields when o_ext_gnt=1, otherwise the CPU fields.
- o_dmem_we = (o_cpu_gnt & i_cpu_we) | (o_ext_gnt & i_ext_we); with no grant, o_dmem_we=0.
- o_cpu_rd = o_ext_rd = i_dmem_rd (broadcast); consumers qualify with their grant.

State S_CPU:
- ext_win = i_ext_req & (~i_cpu_req | starve_cnt==STARVE_MAX).
- o_ext_gnt = ext_win; o_cpu_gnt = i_cpu_req & ~ext_win.
- If ext_win & i_ext_lock & BURST_MAX>1: next S_EXT, burst_cnt<=1.

State S_EXT:
- o_ext_gnt = i_ext_req; o_cpu_gnt = i_cpu_req & ~i_ext_req.
- If o_ext_gnt: burst_cnt<=burst_cnt+1; stay in S_EXT iff i_ext_lock & (burst_cnt+1)<BURST_MAX, else go to S_CPU.
- If i_ext_req=0: go to S_CPU (the CPU is served that cycle).

starve_cnt:
- Cleared when o_ext_gnt=1 or i_ext_req=0.
- Otherwise incremented, saturating at STARVE_MAX.
- Consequence: a pending external request waits at most STARVE_MAX cycles.
- After a forced grant the counter is 0, so the CPU regains priority; no back-to-back starvation of the CPU beyond one burst.

Boundaries:
- Dropping lock mid-burst ends the burst after the current granted cycle.
- Changing external address/data mid-burst is legal; each cycle is an independent access.
- burst_cnt is a don't-care in S_CPU.
- Simultaneous requests from idle: CPU wins.

Test Plan:
- cpu_req=1 every cycle, ext_req=1 (lock=0) from cycle 0 -> ext_gnt=0 for cycles 0-3, ext_gnt=1 at cycle 4, cpu_stall=1 only at cycle 4, cpu_gnt=1 at cycle 5.
- cpu_req=0, ext_req=1, lock=1 held for 12 cycles, BURST_MAX=8 -> ext_gnt=1 in cycles 0-7 (state S_EXT cycles 1-7); cycle 8 back in S_CPU, ext still granted since CPU idle.
- Locked burst with cpu_req=1 throughout -> cpu_stall=1 for 8 cycles, then cpu_gnt=1 for 4 cycles while starve_cnt counts 1..4, then ext_gnt again.
- ext sw 0xDEADBEEF to 0x010 granted, then CPU lw 0x010 next cycle -> o_cpu_rd=0xDEADBEEF, o_dmem_bytectrl equals CPU value; in a cycle with no grant, o_dmem_we=0.
- Reset asserted at burst cycle 3 with ext_we=1 -> o_dmem_we=0 and both grants 0 while rstn=0; after release, state S_CPU and a CPU request is granted immediately.
- ext_req drops mid-burst with cpu_req=1 -> same cycle cpu_gnt=1, ext_gnt=0; next cycle ext_req=1 with lock=1 is denied until starve_cnt=4.
